// File: rtl/otter_pc_ctrl_if.sv
// Control bundle between the Otter sequencing FSM and the surrounding datapath
// (decoder, branch logic, memories, PC register, CSR file).
interface otter_pc_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       OPCODE;
  logic             IS_MRET;
  logic             BR_TAKEN;
  logic             IMEM_RDY;
  logic             DMEM_RDY;
  logic             INTR;
  logic             CSR_MIE;
  logic             PC_RST;
  logic             PC_WE;
  logic [2:0]       PC_SEL;
  logic             IMEM_RDEN;
  logic             DMEM_RDEN;
  logic             DMEM_WE;
  logic             RF_WE;
  logic             INT_TAKEN;
  logic             ILL_OP;
  logic             FETCH_ERR;
  logic [CNT_W-1:0] RETIRED;
  logic [2:0]       STATE;

  modport master (
    input  OPCODE, IS_MRET, BR_TAKEN, IMEM_RDY, DMEM_RDY, INTR, CSR_MIE,
    output PC_RST, PC_WE, PC_SEL, IMEM_RDEN, DMEM_RDEN, DMEM_WE, RF_WE,
           INT_TAKEN, ILL_OP, FETCH_ERR, RETIRED, STATE
  );

  modport slave (
    output OPCODE, IS_MRET, BR_TAKEN, IMEM_RDY, DMEM_RDY, INTR, CSR_MIE,
    input  PC_RST, PC_WE, PC_SEL, IMEM_RDEN, DMEM_RDEN, DMEM_WE, RF_WE,
           INT_TAKEN, ILL_OP, FETCH_ERR, RETIRED, STATE
  );
endinterface

// File: rtl/otter_pc_ctrl.sv
// Multicycle sequencer for the Otter CPU: fetch/exec/writeback/interrupt FSM that
// drives the PC register controls, memory and register-file strobes, and a retire counter.
module otter_pc_ctrl #(
  parameter int FETCH_TIMEOUT = 16,
  parameter int CNT_W         = 32
) (
  input  logic           CLK,
  input  logic           RST_N,
  otter_pc_ctrl_if.master bus
);

  localparam int TW = (FETCH_TIMEOUT > 2) ? $clog2(FETCH_TIMEOUT) : 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] SEL_PC4    = 3'd0;
  localparam logic [2:0] SEL_JALR   = 3'd1;
  localparam logic [2:0] SEL_BRANCH = 3'd2;
  localparam logic [2:0] SEL_JAL    = 3'd3;
  localparam logic [2:0] SEL_MTVEC  = 3'd4;
  localparam logic [2:0] SEL_MEPC   = 3'd5;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WB    = 3'd3,
    S_INTR  = 3'd4
  } state_t;

  state_t           state, state_nxt;
  logic [TW-1:0]    tmo_cnt, tmo_cnt_nxt;
  logic             err_q;
  logic [CNT_W-1:0] retired;

  logic       complete, timeout;
  logic       pc_rst, pc_we, imem_rden, dmem_rden, dmem_we, rf_we, int_taken, ill_op;
  logic [2:0] pc_sel;

  always_comb begin
    state_nxt   = S_INIT;
    tmo_cnt_nxt = tmo_cnt;
    complete    = 1'b0;
    timeout     = 1'b0;
    pc_rst      = 1'b0;
    pc_we       = 1'b0;
    pc_sel      = SEL_PC4;
    imem_rden   = 1'b0;
    dmem_rden   = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    int_taken   = 1'b0;
    ill_op      = 1'b0;

    case (state)
      S_INIT: begin
        pc_rst    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_FETCH: begin
        imem_rden = 1'b1;
        if (bus.IMEM_RDY) begin
          tmo_cnt_nxt = '0;
          state_nxt   = S_EXEC;
        end else if (tmo_cnt == TW'(FETCH_TIMEOUT - 1)) begin
          // Give up on this fetch; restart from PC=0 with the sticky error raised.
          timeout     = 1'b1;
          tmo_cnt_nxt = '0;
          state_nxt   = S_INIT;
        end else begin
          tmo_cnt_nxt = tmo_cnt + TW'(1);
          state_nxt   = S_FETCH;
        end
      end
      S_EXEC: begin
        pc_we    = 1'b1;
        complete = 1'b1;
        if (bus.IS_MRET) begin
          pc_sel = SEL_MEPC;
        end else begin
          case (bus.OPCODE)
            OP_LOAD: begin
              pc_we     = 1'b0;
              dmem_rden = 1'b1;
              complete  = 1'b0;
              state_nxt = S_WB;
            end
            OP_STORE:  dmem_we = 1'b1;
            OP_BRANCH: pc_sel  = bus.BR_TAKEN ? SEL_BRANCH : SEL_PC4;
            OP_JAL: begin
              rf_we  = 1'b1;
              pc_sel = SEL_JAL;
            end
            OP_JALR: begin
              rf_we  = 1'b1;
              pc_sel = SEL_JALR;
            end
            OP_OP, OP_OPIMM, OP_LUI, OP_AUIPC: rf_we = 1'b1;
            default: ill_op = 1'b1;
          endcase
        end
      end
      S_WB: begin
        dmem_rden = 1'b1;
        if (bus.DMEM_RDY) begin
          rf_we    = 1'b1;
          pc_we    = 1'b1;
          complete = 1'b1;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_INTR: begin
        pc_we     = 1'b1;
        pc_sel    = SEL_MTVEC;
        int_taken = 1'b1;
        state_nxt = S_FETCH;
      end
      default: state_nxt = S_INIT;
    endcase

    // Interrupts are only considered at an instruction boundary.
    if (complete) state_nxt = (bus.INTR && bus.CSR_MIE) ? S_INTR : S_FETCH;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= S_INIT;
      tmo_cnt <= '0;
      err_q   <= 1'b0;
      retired <= '0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_cnt_nxt;
      err_q   <= err_q | timeout;
      if (complete) retired <= retired + CNT_W'(1);
    end
  end

  assign bus.PC_RST    = pc_rst;
  assign bus.PC_WE     = pc_we;
  assign bus.PC_SEL    = pc_sel;
  assign bus.IMEM_RDEN = imem_rden;
  assign bus.DMEM_RDEN = dmem_rden;
  assign bus.DMEM_WE   = dmem_we;
  assign bus.RF_WE     = rf_we;
  assign bus.INT_TAKEN = int_taken;
  assign bus.ILL_OP    = ill_op;
  assign bus.FETCH_ERR = err_q | timeout;
  assign bus.RETIRED   = retired;
  assign bus.STATE     = state;

endmodule

// File: tb/tb_otter_pc_ctrl.sv
// Randomised instruction-level bench for otter_pc_ctrl: the driver expands each
// instruction into its expected per-cycle outputs; a negedge monitor pops and compares.
module tb_otter_pc_ctrl;
  localparam int FT = 4;
  localparam int CW = 4;

  localparam logic [6:0] LOAD = 7'b0000011;

  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  always #5 CLK = ~CLK;

  otter_pc_ctrl_if #(.CNT_W(CW)) bus ();
  otter_pc_ctrl #(.FETCH_TIMEOUT(FT), .CNT_W(CW)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));

  typedef struct packed {
    logic [2:0]    st;
    logic          prst;
    logic          pwe;
    logic [2:0]    sel;
    logic          im;
    logic          dr;
    logic          dw;
    logic          rf;
    logic          it;
    logic          ill;
    logic          ferr;
    logic [CW-1:0] ret;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e, mon_g;
  int   n_vec = 0;
  int   n_err = 0;
  int   m_ret = 0;
  logic m_err = 1'b0;

  function automatic exp_t mk(logic [2:0] st, logic prst, logic pwe, logic [2:0] sel,
                              logic im, logic dr, logic dw, logic rf, logic it,
                              logic ill, logic ferr);
    exp_t e;
    e = {st, prst, pwe, sel, im, dr, dw, rf, it, ill, ferr, CW'(m_ret)};
    return e;
  endfunction

  function automatic exp_t observe();
    exp_t g;
    g = {bus.STATE, bus.PC_RST, bus.PC_WE, bus.PC_SEL, bus.IMEM_RDEN, bus.DMEM_RDEN,
         bus.DMEM_WE, bus.RF_WE, bus.INT_TAKEN, bus.ILL_OP, bus.FETCH_ERR, bus.RETIRED};
    return g;
  endfunction

  // Expected EXEC-cycle response for a non-load instruction.
  function automatic void exec_expect(input logic [6:0] op, input logic mret, input logic br,
                                      output logic [2:0] sel, output logic rf,
                                      output logic dw, output logic ill);
    sel = 3'd0; rf = 1'b0; dw = 1'b0; ill = 1'b0;
    if (mret) sel = 3'd5;
    else case (op)
      7'b0100011: dw = 1'b1;
      7'b1100011: sel = br ? 3'd2 : 3'd0;
      7'b1101111: begin rf = 1'b1; sel = 3'd3; end
      7'b1100111: begin rf = 1'b1; sel = 3'd1; end
      7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111: rf = 1'b1;
      default: ill = 1'b1;
    endcase
  endfunction

  always @(negedge CLK) begin
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_g = observe();
      n_vec++;
      if (mon_g !== mon_e)
        begin
          n_err++;
          $display("FAIL cycle @%0t: state got %0d want %0d, outputs got %h want %h",
                   $time, mon_g.st, mon_e.st, mon_g, mon_e);
        end
    end
  end

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rand_in();
    bus.OPCODE   = 7'($urandom);
    bus.IS_MRET  = 1'($urandom);
    bus.BR_TAKEN = 1'($urandom);
    bus.IMEM_RDY = 1'($urandom);
    bus.DMEM_RDY = 1'($urandom);
    bus.INTR     = 1'($urandom);
    bus.CSR_MIE  = 1'($urandom);
  endtask

  task automatic push_init();
    sb.push_back(mk(3'd0, 1, 0, 3'd0, 0, 0, 0, 0, 0, 0, m_err));
  endtask

  // One instruction: fw stalled fetch cycles, lw stalled WB cycles for a load,
  // it/mie are the interrupt inputs on the completing cycle.
  task automatic instr(input logic [6:0] op, input logic mret, input logic br, input int fw,
                       input int lw, input logic it, input logic mie);
    logic [2:0] sel;
    logic rf, dw, ill, done;
    for (int i = 0; i <= fw; i++) begin
      step(); rand_in();
      bus.IMEM_RDY = (i == fw);
      sb.push_back(mk(3'd1, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, m_err));
    end
    step(); rand_in();
    bus.OPCODE = op; bus.IS_MRET = mret; bus.BR_TAKEN = br;
    if (!mret && op == LOAD) begin
      sb.push_back(mk(3'd2, 0, 0, 3'd0, 0, 1, 0, 0, 0, 0, m_err));
      for (int j = 0; j <= lw; j++) begin
        step(); rand_in();
        done = (j == lw);
        bus.DMEM_RDY = done;
        if (done) begin bus.INTR = it; bus.CSR_MIE = mie; end
        sb.push_back(mk(3'd3, 0, done, 3'd0, 0, 1, 0, done, 0, 0, m_err));
      end
    end else begin
      bus.INTR = it; bus.CSR_MIE = mie;
      exec_expect(op, mret, br, sel, rf, dw, ill);
      sb.push_back(mk(3'd2, 0, 1, sel, 0, 0, dw, rf, 0, ill, m_err));
    end
    m_ret = (m_ret + 1) % (1 << CW);
    if (it && mie) begin
      step(); rand_in();
      sb.push_back(mk(3'd4, 0, 1, 3'd4, 0, 0, 0, 0, 1, 0, m_err));
    end
  endtask

  task automatic fetch_timeout();
    for (int i = 0; i < FT; i++) begin
      step(); rand_in();
      bus.IMEM_RDY = 1'b0;
      sb.push_back(mk(3'd1, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, m_err | (i == FT - 1)));
    end
    m_err = 1'b1;
    step(); rand_in();
    push_init();
  endtask

  task automatic reset_mid_wb(input int n_wait);
    step(); rand_in(); bus.IMEM_RDY = 1'b1;
    sb.push_back(mk(3'd1, 0, 0, 3'd0, 1, 0, 0, 0, 0, 0, m_err));
    step(); rand_in(); bus.OPCODE = LOAD; bus.IS_MRET = 1'b0;
    sb.push_back(mk(3'd2, 0, 0, 3'd0, 0, 1, 0, 0, 0, 0, m_err));
    for (int k = 0; k < n_wait; k++) begin
      step(); rand_in(); bus.DMEM_RDY = 1'b0;
      sb.push_back(mk(3'd3, 0, 0, 3'd0, 0, 1, 0, 0, 0, 0, m_err));
    end
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("async_rst_state", 32'(bus.STATE), 32'd0);
    chk("async_rst_pc_rst", 32'(bus.PC_RST), 32'd1);
    chk("async_rst_dmem_rden", 32'(bus.DMEM_RDEN), 32'd0);
    chk("async_rst_strobes", 32'({bus.PC_WE, bus.RF_WE, bus.DMEM_WE, bus.IMEM_RDEN}), 32'd0);
    chk("async_rst_retired", 32'(bus.RETIRED), 32'd0);
    chk("async_rst_fetch_err", 32'(bus.FETCH_ERR), 32'd0);
    m_ret = 0;
    m_err = 1'b0;
    step(); rand_in();
    RST_N = 1'b1;
    push_init();
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, %0d expectations pending", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [10];
    logic [6:0] op;
    int idx, r;
    ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111,
            7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011};

    rand_in();
    repeat (2) @(posedge CLK);
    #1;
    chk("reset_state", 32'(bus.STATE), 32'd0);
    chk("reset_retired", 32'(bus.RETIRED), 32'd0);
    chk("reset_fetch_err", 32'(bus.FETCH_ERR), 32'd0);
    RST_N = 1'b1;
    push_init();

    repeat (3) instr(7'b0010011, 0, 0, 0, 0, 0, 0);
    instr(7'b1100011, 0, 1, 0, 0, 0, 0);
    instr(7'b1100011, 0, 0, 1, 0, 0, 0);
    instr(7'b1101111, 0, 0, 0, 0, 0, 0);
    instr(7'b1100111, 0, 0, 2, 0, 0, 0);
    instr(7'b1111111, 0, 0, 0, 0, 0, 0);
    instr(7'b0000000, 1, 0, 0, 0, 0, 0);
    instr(7'b0100011, 0, 0, FT - 1, 0, 0, 0);
    instr(7'b0110111, 0, 0, 0, 0, 0, 0);
    instr(LOAD, 0, 0, 0, 3, 0, 0);
    instr(LOAD, 0, 0, 0, 1, 1, 1);
    instr(LOAD, 0, 0, 0, 1, 1, 0);
    instr(7'b0110011, 0, 0, 0, 0, 1, 1);
    fetch_timeout();
    instr(7'b0010111, 0, 0, 0, 0, 0, 0);
    fetch_timeout();
    reset_mid_wb(2);

    for (int n = 0; n < 400; n++) begin
      r = $urandom % 100;
      if (r < 3) fetch_timeout();
      else if (r < 5) reset_mid_wb(1 + ($urandom % 3));
      else begin
        idx = $urandom % 12;
        op  = (idx < 10) ? ops[idx] : 7'($urandom);
        instr(op, ($urandom % 10) == 0, 1'($urandom), $urandom % FT, $urandom % 4,
              1'($urandom), 1'($urandom));
      end
    end

    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
